// File: rtl/coin_bank.sv
// Coin credit accumulator: sums coin pulses, handles buy/cancel, paces change pulses (all outputs registered, 1-cycle latency).
// No backpressure: coins are rejected (coin_reject) when they would overflow or while busy; buy/cancel are ignored while busy.
module coin_bank #(
    parameter int unsigned COIN_A      = 1,
    parameter int unsigned COIN_B      = 2,
    parameter int unsigned COIN_C      = 10,
    parameter int unsigned COIN_D      = 20,
    parameter int unsigned CHANGE_GAP  = 3,
    parameter bit          AUTO_CHANGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_a,
    input  logic       coin_b,
    input  logic       coin_c,
    input  logic       coin_d,
    input  logic       buy,
    input  logic [7:0] price,
    input  logic       cancel,
    output logic [7:0] moneyv,
    output logic       vend,
    output logic       chg_one,
    output logic       chg_half,
    output logic       coin_reject,
    output logic       err_insuf,
    output logic       busy
);

    localparam int GW = (CHANGE_GAP > 0) ? $clog2(CHANGE_GAP + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        REFUND = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    money_nxt;
    logic [GW-1:0] gap, gap_nxt;
    logic          vend_nxt, chg_one_nxt, chg_half_nxt, coin_reject_nxt, err_insuf_nxt;
    logic          coin_any;
    logic [8:0]    coin_sum;

    assign coin_any = coin_a | coin_b | coin_c | coin_d;

    // Nine bits so an overflowing deposit is detectable rather than wrapping.
    assign coin_sum = {1'b0, moneyv}
                    + (coin_a ? 9'(COIN_A) : 9'd0)
                    + (coin_b ? 9'(COIN_B) : 9'd0)
                    + (coin_c ? 9'(COIN_C) : 9'd0)
                    + (coin_d ? 9'(COIN_D) : 9'd0);

    assign busy = (state == VEND) || (state == REFUND);

    always_comb begin
        state_nxt       = state;
        money_nxt       = moneyv;
        gap_nxt         = gap;
        vend_nxt        = 1'b0;
        chg_one_nxt     = 1'b0;
        chg_half_nxt    = 1'b0;
        coin_reject_nxt = 1'b0;
        err_insuf_nxt   = 1'b0;

        case (state)
            IDLE, CREDIT: begin
                if ((state == CREDIT) && cancel) begin
                    state_nxt       = REFUND;
                    gap_nxt         = '0;
                    coin_reject_nxt = coin_any;
                end else if (buy && (state == CREDIT) && (price <= moneyv)) begin
                    state_nxt       = VEND;
                    money_nxt       = moneyv - price;
                    vend_nxt        = 1'b1;
                    coin_reject_nxt = coin_any;
                end else begin
                    // Any buy reaching here was refused; coins still count.
                    err_insuf_nxt = buy;
                    if (coin_any) begin
                        if (coin_sum > 9'd255) begin
                            coin_reject_nxt = 1'b1;
                        end else begin
                            money_nxt = coin_sum[7:0];
                        end
                    end
                    state_nxt = (money_nxt != 8'd0) ? CREDIT : IDLE;
                end
            end

            VEND: begin
                coin_reject_nxt = coin_any;
                if (moneyv == 8'd0) begin
                    state_nxt = IDLE;
                end else if (AUTO_CHANGE) begin
                    state_nxt = REFUND;
                    gap_nxt   = '0;
                end else begin
                    state_nxt = CREDIT;
                end
            end

            REFUND: begin
                coin_reject_nxt = coin_any;
                if (moneyv == 8'd0) begin
                    state_nxt = IDLE;
                    gap_nxt   = '0;
                end else if (gap != '0) begin
                    gap_nxt = gap - 1'b1;
                end else begin
                    if (moneyv >= 8'd2) begin
                        chg_one_nxt = 1'b1;
                        money_nxt   = moneyv - 8'd2;
                    end else begin
                        chg_half_nxt = 1'b1;
                        money_nxt    = moneyv - 8'd1;
                    end
                    if (money_nxt == 8'd0) begin
                        state_nxt = IDLE;
                        gap_nxt   = '0;
                    end else begin
                        gap_nxt = GW'(CHANGE_GAP);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            moneyv      <= 8'd0;
            gap         <= '0;
            vend        <= 1'b0;
            chg_one     <= 1'b0;
            chg_half    <= 1'b0;
            coin_reject <= 1'b0;
            err_insuf   <= 1'b0;
        end else begin
            state       <= state_nxt;
            moneyv      <= money_nxt;
            gap         <= gap_nxt;
            vend        <= vend_nxt;
            chg_one     <= chg_one_nxt;
            chg_half    <= chg_half_nxt;
            coin_reject <= coin_reject_nxt;
            err_insuf   <= err_insuf_nxt;
        end
    end

endmodule

// File: tb/tb_coin_bank.sv
// Directed bench for coin_bank with default parameters (CHANGE_GAP=3, AUTO_CHANGE=1).
module tb_coin_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_a, coin_b, coin_c, coin_d;
    logic       buy, cancel;
    logic [7:0] price;
    logic [7:0] moneyv;
    logic       vend, chg_one, chg_half, coin_reject, err_insuf, busy;

    int checks = 0;
    int errors = 0;

    coin_bank #(
        .COIN_A(1), .COIN_B(2), .COIN_C(10), .COIN_D(20),
        .CHANGE_GAP(3), .AUTO_CHANGE(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .coin_a(coin_a), .coin_b(coin_b), .coin_c(coin_c), .coin_d(coin_d),
        .buy(buy), .price(price), .cancel(cancel),
        .moneyv(moneyv), .vend(vend), .chg_one(chg_one), .chg_half(chg_half),
        .coin_reject(coin_reject), .err_insuf(err_insuf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coins(input logic a, input logic b, input logic c, input logic d);
        coin_a = a; coin_b = b; coin_c = c; coin_d = d;
        tick();
        coin_a = 1'b0; coin_b = 1'b0; coin_c = 1'b0; coin_d = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        coin_a = 0; coin_b = 0; coin_c = 0; coin_d = 0;
        buy = 0; cancel = 0; price = 8'd0;
        #3;
        checks++;
        if (moneyv !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: moneyv=%0d busy=%b want 0/0", moneyv, busy);
        end
        checks++;
        if ({vend, chg_one, chg_half, coin_reject, err_insuf} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b want 00000", {vend, chg_one, chg_half, coin_reject, err_insuf});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_coins();
        coins(0, 0, 1, 0);
        checks++;
        if (moneyv !== 8'd10 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL coin_c: moneyv=%0d rej=%b want 10/0", moneyv, coin_reject);
        end
        coins(0, 0, 0, 1);
        checks++;
        if (moneyv !== 8'd30 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL coin_d: moneyv=%0d rej=%b want 30/0", moneyv, coin_reject);
        end
    endtask

    task automatic test_vend_change();
        int         exp_t[3] = '{2, 6, 10};
        logic       exp_o[3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] exp_m[3] = '{8'd3, 8'd1, 8'd0};
        int         pt[3];
        logic       po[3];
        logic [7:0] pm[3];
        int         n;
        n = 0;
        price = 8'd25; buy = 1'b1;
        tick();
        buy = 1'b0;
        checks++;
        if (vend !== 1'b1 || moneyv !== 8'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL vend_pulse: vend=%b moneyv=%0d busy=%b want 1/5/1", vend, moneyv, busy);
        end
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (chg_one || chg_half) begin
                if (n < 3) begin
                    pt[n] = t; po[n] = chg_one; pm[n] = moneyv;
                end
                n++;
            end
            checks++;
            if (vend !== 1'b0 || (chg_one && chg_half)) begin
                errors++;
                $display("FAIL pulse_exclusive t=%0d: vend=%b one=%b half=%b want vend 0, one change pulse max", t, vend, chg_one, chg_half);
            end
            if (t == 9) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid_refund: got %b want 1", busy);
                end
            end
            if (t == 10) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_after_drain: got %b want 0", busy);
                end
            end
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL change_count: got %0d want 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pt[i] !== exp_t[i] || po[i] !== exp_o[i] || pm[i] !== exp_m[i]) begin
                    errors++;
                    $display("FAIL change_%0d: t=%0d one=%b moneyv=%0d want t=%0d one=%b moneyv=%0d",
                             i, pt[i], po[i], pm[i], exp_t[i], exp_o[i], exp_m[i]);
                end
            end
        end
    endtask

    task automatic test_insuf();
        price = 8'd0; buy = 1'b1;
        tick();
        buy = 1'b0;
        checks++;
        if (err_insuf !== 1'b1 || vend !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL buy_in_idle: err=%b vend=%b busy=%b want 1/0/0", err_insuf, vend, busy);
        end
        coins(0, 1, 0, 0);
        coins(0, 1, 0, 0);
        price = 8'd6; buy = 1'b1;
        tick();
        buy = 1'b0;
        checks++;
        if (err_insuf !== 1'b1 || moneyv !== 8'd4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL insufficient: err=%b moneyv=%0d busy=%b want 1/4/0", err_insuf, moneyv, busy);
        end
        price = 8'd2; buy = 1'b1; cancel = 1'b1;
        tick();
        buy = 1'b0; cancel = 1'b0;
        checks++;
        if (vend !== 1'b0 || busy !== 1'b1 || moneyv !== 8'd4 || err_insuf !== 1'b0) begin
            errors++;
            $display("FAIL cancel_beats_buy: vend=%b busy=%b moneyv=%0d err=%b want 0/1/4/0", vend, busy, moneyv, err_insuf);
        end
        tick();
        checks++;
        if (chg_one !== 1'b1 || moneyv !== 8'd2) begin
            errors++;
            $display("FAIL cancel_first_change: one=%b moneyv=%0d want 1/2", chg_one, moneyv);
        end
        for (int i = 0; i < 40 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0 || moneyv !== 8'd0) begin
            errors++;
            $display("FAIL cancel_drain: busy=%b moneyv=%0d want 0/0", busy, moneyv);
        end
    endtask

    task automatic test_refund_reject();
        coins(0, 1, 0, 0);
        coins(0, 1, 0, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        checks++;
        if (chg_one !== 1'b1 || moneyv !== 8'd2) begin
            errors++;
            $display("FAIL refund_first: one=%b moneyv=%0d want 1/2", chg_one, moneyv);
        end
        coins(0, 1, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || moneyv !== 8'd2 || chg_one !== 1'b0) begin
            errors++;
            $display("FAIL refund_coin_reject: rej=%b moneyv=%0d one=%b want 1/2/0", coin_reject, moneyv, chg_one);
        end
        tick();
        tick();
        tick();
        checks++;
        if (chg_one !== 1'b1 || moneyv !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL refund_second: one=%b moneyv=%0d busy=%b want 1/0/0", chg_one, moneyv, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        coins(1, 1, 1, 1);
        checks++;
        if (moneyv !== 8'd33 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL all_coins: moneyv=%0d rej=%b want 33/0", moneyv, coin_reject);
        end
        price = 8'd33; buy = 1'b1; coin_a = 1'b1;
        tick();
        buy = 1'b0; coin_a = 1'b0;
        checks++;
        if (vend !== 1'b1 || moneyv !== 8'd0 || coin_reject !== 1'b1) begin
            errors++;
            $display("FAIL exact_vend_with_coin: vend=%b moneyv=%0d rej=%b want 1/0/1", vend, moneyv, coin_reject);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || vend !== 1'b0 || chg_one !== 1'b0 || chg_half !== 1'b0) begin
            errors++;
            $display("FAIL exact_vend_exit: busy=%b vend=%b one=%b half=%b want 0/0/0/0", busy, vend, chg_one, chg_half);
        end
        coins(0, 1, 0, 0);
        price = 8'd0; buy = 1'b1;
        tick();
        buy = 1'b0;
        checks++;
        if (vend !== 1'b1 || moneyv !== 8'd2) begin
            errors++;
            $display("FAIL free_vend: vend=%b moneyv=%0d want 1/2", vend, moneyv);
        end
        for (int i = 0; i < 40 && busy; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || moneyv !== 8'd0) begin
            errors++;
            $display("FAIL cancel_in_idle: busy=%b moneyv=%0d want 0/0", busy, moneyv);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 12; i++) coins(0, 0, 0, 1);
        coins(0, 0, 1, 0);
        checks++;
        if (moneyv !== 8'd250) begin
            errors++;
            $display("FAIL load_250: moneyv=%0d want 250", moneyv);
        end
        coins(0, 0, 1, 0);
        checks++;
        if (coin_reject !== 1'b1 || moneyv !== 8'd250) begin
            errors++;
            $display("FAIL overflow_reject: rej=%b moneyv=%0d want 1/250", coin_reject, moneyv);
        end
        coins(1, 0, 0, 0);
        checks++;
        if (coin_reject !== 1'b0 || moneyv !== 8'd251) begin
            errors++;
            $display("FAIL after_reject: rej=%b moneyv=%0d want 0/251", coin_reject, moneyv);
        end
        coins(0, 1, 0, 0);
        coins(0, 1, 0, 0);
        checks++;
        if (coin_reject !== 1'b0 || moneyv !== 8'd255) begin
            errors++;
            $display("FAIL fill_255: rej=%b moneyv=%0d want 0/255", coin_reject, moneyv);
        end
        coins(1, 0, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || moneyv !== 8'd255) begin
            errors++;
            $display("FAIL reject_256: rej=%b moneyv=%0d want 1/255", coin_reject, moneyv);
        end
    endtask

    task automatic test_reset_mid_refund();
        int pulses;
        pulses = 0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        checks++;
        if (chg_one !== 1'b1 || moneyv !== 8'd253) begin
            errors++;
            $display("FAIL refund_from_255: one=%b moneyv=%0d want 1/253", chg_one, moneyv);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (moneyv !== 8'd0 || busy !== 1'b0 || chg_one !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: moneyv=%0d busy=%b one=%b want 0/0/0", moneyv, busy, chg_one);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (chg_one || chg_half) pulses++;
        end
        checks++;
        if (pulses !== 0 || moneyv !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: pulses=%0d moneyv=%0d busy=%b want 0/0/0", pulses, moneyv, busy);
        end
    endtask

    initial begin
        test_reset();
        test_coins();
        test_vend_change();
        test_insuf();
        test_refund_reject();
        test_back_to_back();
        test_overflow();
        test_reset_mid_refund();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
